alu_ctrl: RTL

- Sequencing controller that drives the team's 8-bit combinational ALU from the initiator side.
- Accepts register-transfer commands over a valid/ready handshake and issues registered operands and select to the ALU.
- Captures the ALU result into a 4x8 register file and returns it over a valid/ready response channel.
- Sits between a host/testbench command source and the ALU. The ALU is external, connected through the alu_* ports.

---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/alu_ctrl_if.sv | 42 ++++
 rtl/alu_ctrl_regfile.sv | 45 ++++
 rtl/alu_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// Select-field layout, named arithmetic encodings and FSM states.
package alu_ctrl_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_REG = 4;
    localparam int IDX_W   = $clog2(NUM_REG);
    localparam int RPT_W   = 3;
    localparam int SEL_W   = 5;

    localparam int SEL_OP_LSB = 0;
    localparam int SEL_LG_BIT = 2;
    localparam int SEL_SH_LSB = 3;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam logic ARITH = 1'b0;
    localparam logic LOGIC = 1'b1;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_SHL  = 2'b01;
    localparam logic [1:0] SH_SHR  = 2'b10;
    localparam logic [1:0] SH_ZERO = 2'b11;

    // Arithmetic encodings as {op, cin}
    localparam logic [2:0] AR_PASS = 3'b000;
    localparam logic [2:0] AR_INC  = 3'b001;
    localparam logic [2:0] AR_ADD  = 3'b010;
    localparam logic [2:0] AR_ADDC = 3'b011;
    localparam logic [2:0] AR_SUB  = 3'b101;
    localparam logic [2:0] AR_DEC  = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic [SEL_W-1:0] mk_sel(
        input logic [1:0] sh,
        input logic       lg,
        input logic [1:0] op
    );
        return {sh, lg, op};
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Command and response channels between a host and the ALU controller.
// master = command source / result consumer, slave = controller.
interface alu_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int IDXW = IDX_W,
    parameter int RPTW = RPT_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_sel;
    logic             cmd_cin;
    logic [IDXW-1:0]  cmd_dst;
    logic [IDXW-1:0]  cmd_src;
    logic             cmd_imm_en;
    logic [W-1:0]     cmd_imm;
    logic [RPTW-1:0]  cmd_rpt;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic             rsp_zero;

    modport master (
        output cmd_valid, cmd_sel, cmd_cin, cmd_dst,
        output cmd_src, cmd_imm_en, cmd_imm, cmd_rpt,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_cin, cmd_dst,
        input  cmd_src, cmd_imm_en, cmd_imm, cmd_rpt,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_zero,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_ctrl_regfile.sv
// NREG x W register file: one synchronous write port,
// two asynchronous operand reads and one debug read.
module alu_ctrl_regfile #(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int IDXW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [IDXW-1:0] raddr_a,
    output logic [W-1:0]    rdata_a,
    input  logic [IDXW-1:0] raddr_b,
    output logic [W-1:0]    rdata_b,
    input  logic [IDXW-1:0] raddr_d,
    output logic [W-1:0]    rdata_d
);

    logic [W-1:0] mem_q [NREG];
    logic [W-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
    assign rdata_d = mem_q[raddr_d];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller for the external 8-bit ALU: accepts a command,
// issues registered operands, writes back and returns the result.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = NUM_REG,
    parameter int RPTW = RPT_W,
    parameter int IDXW = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_ctrl_if.slave        bus,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_cin,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_o,
    input  logic [IDXW-1:0]  dbg_idx,
    output logic [W-1:0]     dbg_data
);

    state_e state_q, state_d;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             cin_q, cin_d;
    logic [IDXW-1:0]  dst_q, dst_d;
    logic [IDXW-1:0]  src_q, src_d;
    logic             imm_en_q, imm_en_d;
    logic [W-1:0]     imm_q, imm_d;
    logic [RPTW-1:0]  rpt_q, rpt_d;

    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic             alu_cin_q, alu_cin_d;
    logic [W-1:0]     alu_a_q, alu_a_d;
    logic [W-1:0]     alu_b_q, alu_b_d;

    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic             rf_we;
    logic [W-1:0]     rd_a;
    logic [W-1:0]     rd_b;

    alu_ctrl_regfile #(
        .W    (W),
        .NREG (NREG),
        .IDXW (IDXW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (dst_q),
        .wdata   (alu_o),
        .raddr_a (dst_q),
        .rdata_a (rd_a),
        .raddr_b (src_q),
        .rdata_b (rd_b),
        .raddr_d (dbg_idx),
        .rdata_d (dbg_data)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cin_d         = cin_q;
        dst_d         = dst_q;
        src_d         = src_q;
        imm_en_d      = imm_en_q;
        imm_d         = imm_q;
        rpt_d         = rpt_q;
        alu_sel_d     = alu_sel_q;
        alu_cin_d     = alu_cin_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rf_we         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    sel_d    = bus.cmd_sel;
                    cin_d    = bus.cmd_cin;
                    dst_d    = bus.cmd_dst;
                    src_d    = bus.cmd_src;
                    imm_en_d = bus.cmd_imm_en;
                    imm_d    = bus.cmd_imm;
                    rpt_d    = bus.cmd_rpt;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Operand a always tracks the latest reg[dst] on repeats
                alu_a_d   = rd_a;
                alu_b_d   = imm_en_q ? imm_q : rd_b;
                alu_sel_d = sel_q;
                alu_cin_d = cin_q;
                state_d   = WB;
            end
            WB: begin
                rf_we      = 1'b1;
                rsp_data_d = alu_o;
                rsp_zero_d = (alu_o == '0);
                if (rpt_q != '0) begin
                    rpt_d   = rpt_q - RPTW'(1);
                    state_d = ISSUE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cin_q      <= 1'b0;
            dst_q      <= '0;
            src_q      <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            rpt_q      <= '0;
            alu_sel_q  <= '0;
            alu_cin_q  <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cin_q      <= cin_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            imm_en_q   <= imm_en_d;
            imm_q      <= imm_d;
            rpt_q      <= rpt_d;
            alu_sel_q  <= alu_sel_d;
            alu_cin_q  <= alu_cin_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign alu_sel      = alu_sel_q;
    assign alu_cin      = alu_cin_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_zero = rsp_zero_q;

endmodule
